// File: rtl/seq_mul_n.sv
// seq_mul_n -- sequential shift-add multiplier, one partial product per clock.
//
// Produces the exact 2*WIDTH-bit product of two WIDTH-bit operands in either
// unsigned or two's-complement mode (selected per operation). Latency is fixed
// at WIDTH cycles from the accepting edge to done_o; a start in DONE chains a
// new operation with no idle gap.
//
// Ports:
//   clk_i     rising-edge clock
//   rst_i     asynchronous active-high reset
//   start_i   request a multiply; accepted in IDLE or DONE only
//   signed_i  sampled with start_i: 1 = two's-complement, 0 = unsigned
//   a_i       multiplicand, sampled on the accepting edge
//   b_i       multiplier, sampled on the accepting edge
//   busy_o    high while an operation is running
//   done_o    one-cycle pulse when p_o takes a new result
//   p_o       product; held until the next result or reset
module seq_mul_n #(
    parameter int WIDTH = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] p_o
);

    localparam int SW = $clog2(WIDTH + 1);
    localparam logic [SW-1:0] LAST_STEP = SW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    // Datapath registers: multiplicand magnitude, upper accumulator half and
    // the multiplier, which doubles as the lower accumulator half as it shifts.
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mplier;
    logic [SW-1:0]      step;
    logic               neg;

    logic               accept;
    logic               last_step;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   acc_nxt;
    logic [WIDTH-1:0]   mplier_nxt;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] result;

    // Operand magnitudes. The most negative value negates to itself, which
    // read as unsigned is exactly 2^(WIDTH-1), so WIDTH bits always suffice.
    always_comb begin
        a_mag = a_i;
        b_mag = b_i;
        if (signed_i && a_i[WIDTH-1]) begin
            a_mag = ~a_i + WIDTH'(1);
        end
        if (signed_i && b_i[WIDTH-1]) begin
            b_mag = ~b_i + WIDTH'(1);
        end
    end

    // One shift-add iteration. The carry out of the add is the (WIDTH+1)th
    // accumulator bit; it is consumed immediately by the right shift, so it
    // never needs its own register.
    always_comb begin
        sum = {1'b0, acc};
        if (mplier[0]) begin
            sum = {1'b0, acc} + {1'b0, mcand};
        end
        acc_nxt    = sum[WIDTH:1];
        mplier_nxt = {sum[0], mplier[WIDTH-1:1]};
        prod       = {acc_nxt, mplier_nxt};
        // Two's-complement negate; a zero product stays zero.
        result     = neg ? (~prod + (2*WIDTH)'(1)) : prod;
    end

    assign last_step = (step == LAST_STEP);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (last_step) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start_i) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            step   <= '0;
            neg    <= 1'b0;
            p_o    <= '0;
        end else if (accept) begin
            mcand  <= a_mag;
            acc    <= '0;
            mplier <= b_mag;
            step   <= '0;
            neg    <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
        end else if (state == S_RUN) begin
            acc    <= acc_nxt;
            mplier <= mplier_nxt;
            step   <= step + SW'(1);
            // Finalise from the combinational result of the last iteration
            // so the product lands on the same edge that enters DONE.
            if (last_step) begin
                p_o <= result;
            end
        end
    end

    assign busy_o = (state == S_RUN);
    assign done_o = (state == S_DONE);

endmodule
